// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard/forwarding bus between the pipeline (master) and hazard_forward_unit (slave).
// stall_count is present only when HFU_STALL_CNT_EN is defined.
interface hazard_forward_unit_if;
    logic [4:0] id_ra;
    logic [4:0] id_rb;
    logic       id_ra_use;
    logic       id_rb_use;
    logic [4:0] id_rd;
    logic       id_rf_le;
    logic       id_load;
    logic       ex_jump;
    logic [1:0] fw_a_sel;
    logic [1:0] fw_b_sel;
    logic       nop_sel;
    logic       pc_le;
    logic       ifid_le;
    logic       squash;
`ifdef HFU_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    modport master (
        output id_ra, id_rb, id_ra_use, id_rb_use, id_rd, id_rf_le, id_load, ex_jump,
        input  fw_a_sel, fw_b_sel, nop_sel, pc_le, ifid_le, squash
`ifdef HFU_STALL_CNT_EN
        , input stall_count
`endif
    );

    modport slave (
        input  id_ra, id_rb, id_ra_use, id_rb_use, id_rd, id_rf_le, id_load, ex_jump,
        output fw_a_sel, fw_b_sel, nop_sel, pc_le, ifid_le, squash
`ifdef HFU_STALL_CNT_EN
        , output stall_count
`endif
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding select and load-use / jump hazard control from a 3-entry shadow pipeline.
// Optional feature macro: HFU_STALL_CNT_EN adds a saturating load-use stall counter.
module hazard_forward_unit (
    input  logic             clk,
    input  logic             rst_n,
    hazard_forward_unit_if.slave bus
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_EX  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b11;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;

    logic [SEL_W-1:0] fw_a_c, fw_b_c;
    logic             load_use_c;
    logic             jump_c;
    logic             nop_c;
    logic             squash_c;
    logic             stall_c;

    function automatic logic stage_hit(input stage_t st, input logic [REG_W-1:0] src);
        return st.we && (st.rd == src) && (src != REG_W'(0));
    endfunction

    // Youngest producer wins; unused sources always read the register file.
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src, input logic use_src,
                                                 input stage_t ex, input stage_t mem, input stage_t wb);
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (use_src) begin
            if (stage_hit(ex, src))       sel = SEL_EX;
            else if (stage_hit(mem, src)) sel = SEL_MEM;
            else if (stage_hit(wb, src))  sel = SEL_WB;
        end
        return sel;
    endfunction

    // Hazard decode; a jump in EX discards the ID instruction so its load-use hazard is moot.
    always_comb begin
        fw_a_c     = fwd_sel(bus.id_ra, bus.id_ra_use, ex_q, mem_q, wb_q);
        fw_b_c     = fwd_sel(bus.id_rb, bus.id_rb_use, ex_q, mem_q, wb_q);
        load_use_c = ex_q.ld && ((bus.id_ra_use && stage_hit(ex_q, bus.id_ra)) ||
                                 (bus.id_rb_use && stage_hit(ex_q, bus.id_rb)));
        jump_c     = bus.ex_jump && rst_n;
        stall_c    = load_use_c && !jump_c;
        squash_c   = jump_c;
        nop_c      = stall_c || jump_c;
    end

    assign bus.fw_a_sel = fw_a_c;
    assign bus.fw_b_sel = fw_b_c;
    assign bus.nop_sel  = nop_c;
    assign bus.squash   = squash_c;
    assign bus.pc_le    = !stall_c;
    assign bus.ifid_le  = !stall_c;

    // Shadow pipeline; a bubble enters EX whenever the NOP mux is forced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q.rd  <= bus.id_rd;
            ex_q.we  <= bus.id_rf_le && !nop_c;
            ex_q.ld  <= bus.id_load && !nop_c;
        end
    end

`ifdef HFU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven check of hazard_forward_unit forwarding, stall, squash and reset behaviour.
// Define HFU_STALL_CNT_EN to also check the stall counter and its saturation.
module tb_hazard_forward_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_forward_unit_if bus ();

    hazard_forward_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ra;
        logic [4:0] rb;
        logic       ra_use;
        logic       rb_use;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       jmp;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       enop;
        logic       epc;
        logic       eifid;
        logic       esq;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic rau,
                                input logic rbu, input logic [4:0] rd, input logic we,
                                input logic ld, input logic jmp, input logic [1:0] ea,
                                input logic [1:0] eb, input logic enop, input logic epc,
                                input logic eifid, input logic esq);
        vec_t v;
        v.ra = ra; v.rb = rb; v.ra_use = rau; v.rb_use = rbu;
        v.rd = rd; v.we = we; v.ld = ld; v.jmp = jmp;
        v.ea = ea; v.eb = eb; v.enop = enop; v.epc = epc; v.eifid = eifid; v.esq = esq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic rau,
                         input logic rbu, input logic [4:0] rd, input logic we,
                         input logic ld, input logic jmp);
        bus.id_ra = ra; bus.id_rb = rb; bus.id_ra_use = rau; bus.id_rb_use = rbu;
        bus.id_rd = rd; bus.id_rf_le = we; bus.id_load = ld; bus.ex_jump = jmp;
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                            input logic enop, input logic epc, input logic eifid, input logic esq);
        chk({tag, ".fw_a"},   32'(bus.fw_a_sel), 32'(ea));
        chk({tag, ".fw_b"},   32'(bus.fw_b_sel), 32'(eb));
        chk({tag, ".nop"},    32'(bus.nop_sel),  32'(enop));
        chk({tag, ".pc_le"},  32'(bus.pc_le),    32'(epc));
        chk({tag, ".ifid"},   32'(bus.ifid_le),  32'(eifid));
        chk({tag, ".squash"}, 32'(bus.squash),   32'(esq));
    endtask

    initial begin
        int exp_stalls;
        total = 0;
        bad   = 0;
        exp_stalls = 0;

        //      ra rb rau rbu rd we ld jmp  ea eb nop pc ifid sq
        vt[0]  = mk(0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 1, 1, 0);
        vt[1]  = mk(3, 0, 1, 0, 3, 1, 0, 0,  1, 0, 0, 1, 1, 0);
        vt[2]  = mk(3, 4, 1, 1, 3, 1, 0, 0,  1, 0, 0, 1, 1, 0);
        vt[3]  = mk(3, 4, 1, 1, 7, 1, 0, 1,  1, 0, 1, 1, 1, 1);
        vt[4]  = mk(3, 3, 1, 1, 0, 0, 0, 0,  2, 2, 0, 1, 1, 0);
        vt[5]  = mk(3, 4, 1, 1, 5, 1, 1, 0,  3, 0, 0, 1, 1, 0);
        vt[6]  = mk(5, 2, 1, 1, 6, 1, 0, 0,  1, 0, 1, 0, 0, 0);
        vt[7]  = mk(5, 2, 1, 1, 6, 1, 0, 0,  2, 0, 0, 1, 1, 0);
        vt[8]  = mk(6, 5, 1, 1, 0, 1, 0, 0,  1, 3, 0, 1, 1, 0);
        vt[9]  = mk(0, 6, 1, 0, 5, 1, 1, 0,  0, 0, 0, 1, 1, 0);
        vt[10] = mk(5, 0, 1, 1, 9, 1, 0, 1,  1, 0, 1, 1, 1, 1);
        vt[11] = mk(5, 0, 1, 1, 8, 1, 1, 0,  2, 0, 0, 1, 1, 0);
        vt[12] = mk(1, 8, 0, 1, 9, 1, 0, 0,  0, 1, 1, 0, 0, 0);
        vt[13] = mk(1, 8, 0, 1, 9, 1, 0, 0,  0, 2, 0, 1, 1, 0);

        // Reset state, with ID inputs that would otherwise look hazardous.
        rst_n = 1'b0;
        drive(5, 5, 1, 1, 5, 1, 1, 0);
        #2;
        chk_ctrl("reset", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HFU_STALL_CNT_EN
        chk("reset.stall_count", 32'(bus.stall_count), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].ra, vt[i].rb, vt[i].ra_use, vt[i].rb_use,
                  vt[i].rd, vt[i].we, vt[i].ld, vt[i].jmp);
            #2;
            chk_ctrl($sformatf("vec%0d", i), vt[i].ea, vt[i].eb,
                     vt[i].enop, vt[i].epc, vt[i].eifid, vt[i].esq);
            if (vt[i].enop && !vt[i].esq) exp_stalls++;
            @(negedge clk);
        end

`ifdef HFU_STALL_CNT_EN
        chk("table.stall_count", 32'(bus.stall_count), 32'(exp_stalls));
`endif

        // Reset dropped in the middle of a load-use stall cycle.
        drive(0, 0, 0, 0, 5, 1, 1, 0);
        @(negedge clk);
        drive(5, 0, 1, 0, 6, 1, 0, 0);
        #2;
        chk_ctrl("pre_rst_stall", 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_ctrl("rst_mid_stall", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 5, 1, 1, 0, 0, 0, 0);
        #2;
        chk_ctrl("post_rst", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HFU_STALL_CNT_EN
        chk("post_rst.stall_count", 32'(bus.stall_count), 32'd0);
`endif
        @(negedge clk);

`ifdef HFU_STALL_CNT_EN
        // Saturation: alternate load R5 / use R5 so every other cycle stalls.
        for (int n = 0; n < 70000; n++) begin
            drive(0, 0, 0, 0, 5, 1, 1, 0);
            @(negedge clk);
            drive(5, 0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        chk("sat.stall_count", 32'(bus.stall_count), 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: id_ra, id_rb  input  5 each  source register numbers of the instruction in ID.
REQ-004: id_ra_use, id_rb_use  input  1 each  ID instruction reads RA / RB.
REQ-005: id_rd  input  5  target register already selected for the ID instruction.
REQ-006: id_rf_le  input  1  ID instruction writes the register file.
REQ-007: id_load  input  1  ID instruction is a memory load.
REQ-008: ex_jump  input  1  taken jump resolved in EX this cycle.
REQ-009: fw_a_sel, fw_b_sel  output  2 each  forwarding select for operands A / B: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-010: nop_sel  output  1  forces the control-unit NOP mux; 1 inserts a bubble into EX.
REQ-011: pc_le, ifid_le  output  1 each  load enables for PC and IF/ID; 0 holds.
REQ-012: squash  output  1  clears IF/ID to a NOP at the next edge.
REQ-013: stall_count  output  16  cumulative load-use stall cycles; present only under HFU_STALL_CNT_EN.

Function
REQ-014: Hold a shadow pipeline of three stage entries (EX, MEM, WB), each holding rd[4:0], we and ld.
REQ-015: Each edge: WB takes MEM, MEM takes EX, EX takes {id_rd, id_rf_le, id_load}.
REQ-016: When nop_sel=1 or squash=1, the EX entry loads we=0, ld=0 (bubble).
REQ-017: A stage matches a source when the stage we=1, stage rd equals the source, and the source is nonzero. GR0 is never forwarded.
REQ-018: The forwarding select is combinational on state and ID inputs.
- Priority is EX (01) > MEM (10) > WB (11) > register file (00).
- A source whose use bit is 0 selects 00.
REQ-019: Load-use hazard exists when EX ld=1, EX we=1, EX rd is nonzero, and EX rd matches id_ra with id_ra_use=1 or id_rb with id_rb_use=1.
REQ-020: On a load-use hazard with ex_jump=0, assert nop_sel=1, pc_le=0, ifid_le=0 for exactly one cycle.
- Next cycle the load sits in MEM and forwards with select 10.
REQ-021: On ex_jump=1, assert squash=1, nop_sel=1, pc_le=1, ifid_le=1.
- A simultaneous load-use hazard is ignored, because the ID instruction is discarded.
REQ-022: With no hazard and no jump: nop_sel=0, squash=0, pc_le=1, ifid_le=1.
REQ-023: The unit holds no multi-cycle stall state. A stall lasts one cycle because the bubble clears the EX match.
REQ-024: Latency: select and stall outputs are valid in the same cycle as the ID inputs; shadow state updates at the next edge.

Reset
REQ-025: While rst_n=0, all stage entries clear (rd=0, we=0, ld=0) asynchronously.
REQ-026: Outputs during and after reset until the first hazard:
- fw_a_sel=fw_b_sel=00, nop_sel=0, squash=0, pc_le=1, ifid_le=1.
- stall_count=0.
REQ-027: Reset asserted mid-stall cancels the stall immediately; no bubble survives reset.

Configuration
REQ-028: Macro HFU_STALL_CNT_EN.
- Defined: stall_count exists, increments by 1 on every edge where nop_sel=1 and squash=0, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-029: ID adds R3 and R4 after EX, MEM and WB all write R3 -> fw_a_sel=01; next cycle with EX bubbled -> 10.
REQ-030: Load to R5 followed by a use of R5 -> one cycle with nop_sel=1, pc_le=0, ifid_le=0; next cycle fw_a_sel=10, no stall.
REQ-031: Write to R0 in EX, then ID reads R0 -> fw_a_sel=00, no stall.
REQ-032: Load-use hazard with ex_jump=1 in the same cycle -> squash=1, pc_le=1, no stall; stall_count unchanged.
REQ-033: rst_n dropped during a stall cycle -> outputs return to their reset values immediately, and entries are clear after release.
REQ-034 (HFU_STALL_CNT_EN): 70000 back-to-back load-use stalls -> stall_count holds at 16'hFFFF.
